lcd_timing_gen: RTL and testbench
=================================

Name: lcd_timing_gen

Overview:
- Parametrised RGB LCD timing generator and pixel pipeline; successor of the fixed 800x480 DE-only driver.
- Sits between the frame source (SDRAM read FIFO, pattern generator or line buffer) and the RGB panel pins.
- Adds:
  - parametrised timing and data width
  - HV+DE or DE-only sync mode with programmable sync polarity
  - configurable source read latency
  - panel power-up/reset sequencer FSM
  - frame-boundary display enable, plus frame/line status pulses.

Parameters:
- DATA_W, 16, pixel width (16 = RGB565, 24 = RGB888).
- CNT_W, 12, width of the h/v counters and of pixel_xpos/pixel_ypos.
- H_SYNC/H_BACK/H_DISP/H_FRONT, 128/88/800/40, horizontal timing in pixel clocks. H_TOTAL is derived as the sum.
- V_SYNC/V_BACK/V_DISP/V_FRONT, 2/33/480/10, vertical timing in lines. V_TOTAL is derived as the sum.
- SYNC_MODE, 0, 0 = DE-only (hs/vs held at their inactive level); 1 = HV+DE.
- HS_POL/VS_POL, 0, sync active level (0 = active-low).
- RD_LAT, 1, cycles from data_req to valid pixel_data. Legal range 0..3 and must be less than H_SYNC+H_BACK.
- BLANK_COLOR, 0, lcd_rgb value whenever lcd_de is low.
- RST_CYCLES, 20'd50000, cycles lcd_rst is held low after reset.
- WAKE_CYCLES, 20'd50000, cycles after lcd_rst rises before the timing counters start.

Ports:
- lcd_clk, in, 1, pixel clock. The sole clock.
- sys_rst, in, 1, synchronous active-high reset.
- disp_en, in, 1, display on request. Sampled only at frame end.
- pixel_data, in, DATA_W, pixel from the source. Valid RD_LAT cycles after data_req.
- data_req, out, 1, pixel request.
- pixel_xpos, out, CNT_W, column of the requested pixel (0-based).
- pixel_ypos, out, CNT_W, row of the requested pixel (0-based).
- frame_start, out, 1, one-cycle pulse at cnt_h=0, cnt_v=0 while in RUN.
- line_start, out, 1, one-cycle pulse at cnt_h=0 while in RUN.
- lcd_hs, out, 1, horizontal sync.
- lcd_vs, out, 1, vertical sync.
- lcd_de, out, 1, data enable.
- lcd_rgb, out, DATA_W, pixel data to the panel.
- lcd_bl, out, 1, backlight enable.
- lcd_rst, out, 1, panel reset (active-low).
- lcd_pclk, out, 1, equal to lcd_clk.

Behaviour:
- Reset (sys_rst=1, synchronous; also applies mid-frame):
  - FSM goes to RST_HOLD; sequencer count, cnt_h and cnt_v are cleared to 0.
  - disp_on=0.
  - Outputs: lcd_rst=0, lcd_bl=0, lcd_de=0, lcd_rgb=BLANK_COLOR, data_req=0, xpos=ypos=0, frame_start=line_start=0.
  - lcd_hs/lcd_vs sit at their inactive level (~HS_POL / ~VS_POL).
- FSM:
  - RST_HOLD: lcd_rst=0 for RST_CYCLES cycles, then go to WAKE.
  - WAKE: lcd_rst=1; counters held at 0; after WAKE_CYCLES cycles go to RUN.
  - RUN: counters run. RUN exits only through reset.
- Counters (RUN only):
  - cnt_h counts 0..H_TOTAL-1 and wraps.
  - cnt_v increments when cnt_h=H_TOTAL-1 and wraps from V_TOTAL-1 to 0.
- Derived values: HA=H_SYNC+H_BACK, VA=V_SYNC+V_BACK.
  - v_act is true for cnt_v in [VA, VA+V_DISP).
  - de_raw is true when v_act is true and cnt_h is in [HA, HA+H_DISP).
- Display enable gating:
  - disp_on loads from disp_en only on the cycle cnt_h=H_TOTAL-1 and cnt_v=V_TOTAL-1. A disp_en change mid-frame has no effect until the next frame.
  - lcd_bl equals disp_on (registered).
- Data request:
  - data_req (combinational from the counters) is high when disp_on=1, v_act=1, and cnt_h is in [HA-RD_LAT, HA+H_DISP-RD_LAT).
  - While data_req=1: pixel_xpos = cnt_h-(HA-RD_LAT) and pixel_ypos = cnt_v-VA. Otherwise both are 0.
  - Exactly H_DISP requests per active line, V_DISP lines per frame.
- Output stage (all panel outputs registered, 1-cycle latency from counter state):
  - lcd_de is de_raw & disp_on delayed by 1 cycle.
  - lcd_rgb loads pixel_data when de_raw & disp_on, otherwise BLANK_COLOR.
  - The pixel requested at cycle t therefore appears on lcd_rgb at cycle t+RD_LAT+1.
- Sync outputs:
  - SYNC_MODE=1: lcd_hs = HS_POL when cnt_h<H_SYNC, else ~HS_POL. lcd_vs = VS_POL when cnt_v<V_SYNC, else ~VS_POL. Both are registered with the same 1-cycle delay as lcd_de.
  - SYNC_MODE=0: lcd_hs/lcd_vs are constant at their inactive level.
  - Sync keeps running while disp_on=0, so panel timing never stops.
- Status pulses: frame_start and line_start are registered with the same 1-cycle delay. Both fire on the same cycle at frame start.

Test Plan:
- Bench parameters for all scenarios: H 2/3/8/2 (H_TOTAL=15), V 1/2/4/1 (V_TOTAL=8), RD_LAT=1, RST_CYCLES=4, WAKE_CYCLES=3, SYNC_MODE=1, HS_POL=VS_POL=0, BLANK_COLOR=16'hFFFF, disp_en=1.
- Reset sequence: release sys_rst -> lcd_rst low for 4 cycles, then high. frame_start pulses 3 cycles after lcd_rst rises plus 1 output cycle. lcd_bl stays 0 for the whole first frame.
- Request/position (second frame): data_req high at cnt_h 4..11 on rows cnt_v 3..6 -> xpos 0..7, ypos 0..3. Exactly 32 requests per frame.
- Data alignment: source returns pixel_data = {ypos,xpos} one cycle after each request -> lcd_rgb shows 0x0000..0x0007 with lcd_de high, 8 cycles per line. Between lines lcd_rgb=16'hFFFF.
- Sync/polarity: lcd_hs low for 2 cycles per 15-cycle line and lcd_vs low for 1 line per frame. With SYNC_MODE=0 both stay constant 1 while lcd_de is unchanged.
- Enable gating: drop disp_en mid-frame -> that frame completes normally; next frame has 0 data_req, lcd_de=0 and lcd_bl=0 while hs/vs continue. Raising disp_en restores output at the following frame.
- Mid-frame reset: assert sys_rst while lcd_de=1 -> next cycle lcd_de=0, lcd_rst=0, lcd_rgb=16'hFFFF, counters=0, and the full RST_HOLD/WAKE sequence repeats.

Source files
------------

// File: rtl/lcd_timing_gen.sv
// Parametrised RGB LCD timing generator: panel power-up sequencer, h/v counters,
// source request generation and a registered panel output stage.
module lcd_timing_gen #(
    parameter int                 DATA_W      = 16,
    parameter int                 CNT_W       = 12,
    parameter int                 H_SYNC      = 128,
    parameter int                 H_BACK      = 88,
    parameter int                 H_DISP      = 800,
    parameter int                 H_FRONT     = 40,
    parameter int                 V_SYNC      = 2,
    parameter int                 V_BACK      = 33,
    parameter int                 V_DISP      = 480,
    parameter int                 V_FRONT     = 10,
    parameter bit                 SYNC_MODE   = 1'b0,
    parameter bit                 HS_POL      = 1'b0,
    parameter bit                 VS_POL      = 1'b0,
    parameter int                 RD_LAT      = 1,
    parameter logic [DATA_W-1:0]  BLANK_COLOR = '0,
    parameter logic [19:0]        RST_CYCLES  = 20'd50000,
    parameter logic [19:0]        WAKE_CYCLES = 20'd50000
) (
    input  logic              lcd_clk,
    input  logic              sys_rst,
    input  logic              disp_en,
    input  logic [DATA_W-1:0] pixel_data,
    output logic              data_req,
    output logic [CNT_W-1:0]  pixel_xpos,
    output logic [CNT_W-1:0]  pixel_ypos,
    output logic              frame_start,
    output logic              line_start,
    output logic              lcd_hs,
    output logic              lcd_vs,
    output logic              lcd_de,
    output logic [DATA_W-1:0] lcd_rgb,
    output logic              lcd_bl,
    output logic              lcd_rst,
    output logic              lcd_pclk
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
    localparam int HA      = H_SYNC + H_BACK;
    localparam int VA      = V_SYNC + V_BACK;

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] HA_LO  = CNT_W'(HA);
    localparam logic [CNT_W-1:0] HA_HI  = CNT_W'(HA + H_DISP);
    localparam logic [CNT_W-1:0] VA_LO  = CNT_W'(VA);
    localparam logic [CNT_W-1:0] VA_HI  = CNT_W'(VA + V_DISP);
    localparam logic [CNT_W-1:0] REQ_LO = CNT_W'(HA - RD_LAT);
    localparam logic [CNT_W-1:0] REQ_HI = CNT_W'(HA + H_DISP - RD_LAT);

    typedef enum logic [1:0] {
        RST_HOLD,
        WAKE,
        RUN
    } state_t;

    state_t      state, state_nxt;
    logic [19:0] seq_cnt, seq_cnt_nxt;
    logic [CNT_W-1:0] cnt_h, cnt_v;
    logic        disp_on;
    logic        run, line_end, frame_end;
    logic        v_act, h_act, h_req, de_raw, de_gated;

    // ---------------- power-up sequencer ----------------
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt   = state;
        seq_cnt_nxt = seq_cnt + 20'd1;
        case (state)
            RST_HOLD: begin
                if (seq_cnt == RST_CYCLES - 20'd1) begin
                    state_nxt   = WAKE;
                    seq_cnt_nxt = '0;
                end
            end
            WAKE: begin
                if (seq_cnt == WAKE_CYCLES - 20'd1) begin
                    state_nxt   = RUN;
                    seq_cnt_nxt = '0;
                end
            end
            RUN:     seq_cnt_nxt = '0;
            default: begin
                state_nxt   = RST_HOLD;
                seq_cnt_nxt = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge lcd_clk) begin
        if (sys_rst) begin
            state   <= RST_HOLD;
            seq_cnt <= '0;
            lcd_rst <= 1'b0;
        end else begin
            state   <= state_nxt;
            seq_cnt <= seq_cnt_nxt;
            lcd_rst <= (state_nxt != RST_HOLD);  // registered so the panel reset pin never glitches
        end
    end

    assign run = (state == RUN);

    // ---------------- timing counters ----------------
    assign line_end  = run && (cnt_h == H_LAST);
    assign frame_end = line_end && (cnt_v == V_LAST);

    always_ff @(posedge lcd_clk) begin
        if (sys_rst || !run) begin
            cnt_h <= '0;
            cnt_v <= '0;
        end else if (line_end) begin
            cnt_h <= '0;
            cnt_v <= (cnt_v == V_LAST) ? '0 : cnt_v + 1'b1;
        end else begin
            cnt_h <= cnt_h + 1'b1;
        end
    end

    // Display enable only changes on a frame boundary so a frame is never cut short.
    always_ff @(posedge lcd_clk) begin
        if (sys_rst)
            disp_on <= 1'b0;
        else if (frame_end)
            disp_on <= disp_en;
    end

    assign lcd_bl = disp_on;

    // ---------------- active window and source requests ----------------
    assign v_act    = (cnt_v >= VA_LO) && (cnt_v < VA_HI);
    assign h_act    = (cnt_h >= HA_LO) && (cnt_h < HA_HI);
    assign h_req    = (cnt_h >= REQ_LO) && (cnt_h < REQ_HI);
    assign de_raw   = run && v_act && h_act;
    assign de_gated = de_raw && disp_on;

    // Requests lead the active window by RD_LAT so data arrives just as DE opens.
    assign data_req   = run && disp_on && v_act && h_req;
    assign pixel_xpos = data_req ? cnt_h - REQ_LO : '0;
    assign pixel_ypos = data_req ? cnt_v - VA_LO  : '0;

    // ---------------- registered panel output stage ----------------
    always_ff @(posedge lcd_clk) begin
        if (sys_rst) begin
            lcd_de      <= 1'b0;
            lcd_rgb     <= BLANK_COLOR;
            lcd_hs      <= ~HS_POL;
            lcd_vs      <= ~VS_POL;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
        end else begin
            lcd_de      <= de_gated;
            lcd_rgb     <= de_gated ? pixel_data : BLANK_COLOR;
            lcd_hs      <= (SYNC_MODE && run && (cnt_h < HS_END)) ? HS_POL : ~HS_POL;
            lcd_vs      <= (SYNC_MODE && run && (cnt_v < VS_END)) ? VS_POL : ~VS_POL;
            frame_start <= run && (cnt_h == '0) && (cnt_v == '0);
            line_start  <= run && (cnt_h == '0);
        end
    end

    assign lcd_pclk = lcd_clk;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Directed bench for lcd_timing_gen on a 15x8 miniature panel; a second instance
// with SYNC_MODE=0 shares all inputs to confirm DE-only behaviour.
module tb_lcd_timing_gen;

    logic        clk = 1'b0;
    logic        sys_rst;
    logic        disp_en;
    logic [15:0] pixel_data;
    logic [15:0] pend;

    logic        data_req, frame_start, line_start, lcd_hs, lcd_vs, lcd_de, lcd_bl, lcd_rst, lcd_pclk;
    logic [11:0] pixel_xpos, pixel_ypos;
    logic [15:0] lcd_rgb;

    logic        data_req_b, frame_start_b, line_start_b, lcd_hs_b, lcd_vs_b, lcd_de_b, lcd_bl_b, lcd_rst_b, lcd_pclk_b;
    logic [11:0] pixel_xpos_b, pixel_ypos_b;
    logic [15:0] lcd_rgb_b;

    int tests_run    = 0;
    int tests_failed = 0;
    int req_cnt      = 0;
    int fen[6];

    always #5 clk = ~clk;

    lcd_timing_gen #(
        .DATA_W(16), .CNT_W(12),
        .H_SYNC(2), .H_BACK(3), .H_DISP(8), .H_FRONT(2),
        .V_SYNC(1), .V_BACK(2), .V_DISP(4), .V_FRONT(1),
        .SYNC_MODE(1'b1), .HS_POL(1'b0), .VS_POL(1'b0), .RD_LAT(1),
        .BLANK_COLOR(16'hFFFF), .RST_CYCLES(20'd4), .WAKE_CYCLES(20'd3)
    ) dut (
        .lcd_clk(clk), .sys_rst(sys_rst), .disp_en(disp_en), .pixel_data(pixel_data),
        .data_req(data_req), .pixel_xpos(pixel_xpos), .pixel_ypos(pixel_ypos),
        .frame_start(frame_start), .line_start(line_start),
        .lcd_hs(lcd_hs), .lcd_vs(lcd_vs), .lcd_de(lcd_de), .lcd_rgb(lcd_rgb),
        .lcd_bl(lcd_bl), .lcd_rst(lcd_rst), .lcd_pclk(lcd_pclk)
    );

    lcd_timing_gen #(
        .DATA_W(16), .CNT_W(12),
        .H_SYNC(2), .H_BACK(3), .H_DISP(8), .H_FRONT(2),
        .V_SYNC(1), .V_BACK(2), .V_DISP(4), .V_FRONT(1),
        .SYNC_MODE(1'b0), .HS_POL(1'b0), .VS_POL(1'b0), .RD_LAT(1),
        .BLANK_COLOR(16'hFFFF), .RST_CYCLES(20'd4), .WAKE_CYCLES(20'd3)
    ) dut_de_only (
        .lcd_clk(clk), .sys_rst(sys_rst), .disp_en(disp_en), .pixel_data(pixel_data),
        .data_req(data_req_b), .pixel_xpos(pixel_xpos_b), .pixel_ypos(pixel_ypos_b),
        .frame_start(frame_start_b), .line_start(line_start_b),
        .lcd_hs(lcd_hs_b), .lcd_vs(lcd_vs_b), .lcd_de(lcd_de_b), .lcd_rgb(lcd_rgb_b),
        .lcd_bl(lcd_bl_b), .lcd_rst(lcd_rst_b), .lcd_pclk(lcd_pclk_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One pixel clock; the source answers each request one cycle later with {ypos,xpos}.
    task automatic tick();
        @(posedge clk);
        #1;
        pixel_data = pend;
        pend = data_req ? {pixel_ypos[7:0], pixel_xpos[7:0]} : 16'hBEEF;
    endtask

    // Entered one sample after a reset edge; leaves at the first RUN cycle (n=0).
    task automatic reset_seq(input string name);
        check({name, "_rst"},   32'(lcd_rst),     32'd0);
        check({name, "_bl"},    32'(lcd_bl),      32'd0);
        check({name, "_de"},    32'(lcd_de),      32'd0);
        check({name, "_rgb"},   32'(lcd_rgb),     32'hFFFF);
        check({name, "_req"},   32'(data_req),    32'd0);
        check({name, "_xpos"},  32'(pixel_xpos),  32'd0);
        check({name, "_ypos"},  32'(pixel_ypos),  32'd0);
        check({name, "_fs"},    32'(frame_start), 32'd0);
        check({name, "_ls"},    32'(line_start),  32'd0);
        check({name, "_hs"},    32'(lcd_hs),      32'd1);
        check({name, "_vs"},    32'(lcd_vs),      32'd1);
        check({name, "_de_b"},  32'(lcd_de_b),    32'd0);
        check({name, "_pclk"},  32'(lcd_pclk),    32'd1);
        sys_rst = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            check($sformatf("%s_rst@%0d", name, k), 32'(lcd_rst),     32'(k >= 4));
            check($sformatf("%s_fs@%0d",  name, k), 32'(frame_start), 32'd0);
            check($sformatf("%s_bl@%0d",  name, k), 32'(lcd_bl),      32'd0);
            check($sformatf("%s_req@%0d", name, k), 32'(data_req),    32'd0);
        end
    endtask

    // n = RUN cycle index: cnt_h = n%15, cnt_v = (n/15)%8, frame = n/120.
    task automatic check_cycle(input int n);
        int h, v, f, m, hm, vm, fm;
        logic req_e, de_e, hs_e, vs_e, fs_e, ls_e;
        logic [15:0] rgb_e;
        h = n % 15;
        v = (n / 15) % 8;
        f = n / 120;
        req_e = (fen[f] != 0) && v >= 3 && v <= 6 && h >= 4 && h <= 11;
        check($sformatf("req@%0d",  n), 32'(data_req),   32'(req_e));
        check($sformatf("xpos@%0d", n), 32'(pixel_xpos), req_e ? 32'(h - 4) : 32'd0);
        check($sformatf("ypos@%0d", n), 32'(pixel_ypos), req_e ? 32'(v - 3) : 32'd0);
        check($sformatf("bl@%0d",   n), 32'(lcd_bl),     32'(fen[f]));
        check($sformatf("rst@%0d",  n), 32'(lcd_rst),    32'd1);
        check($sformatf("req_b@%0d", n), 32'(data_req_b), 32'(req_e));

        if (n == 0) begin
            de_e = 1'b0; rgb_e = 16'hFFFF; hs_e = 1'b1; vs_e = 1'b1; fs_e = 1'b0; ls_e = 1'b0;
        end else begin
            m  = n - 1;
            hm = m % 15;
            vm = (m / 15) % 8;
            fm = m / 120;
            de_e  = (fen[fm] != 0) && vm >= 3 && vm <= 6 && hm >= 5 && hm <= 12;
            rgb_e = de_e ? {8'(vm - 3), 8'(hm - 5)} : 16'hFFFF;
            hs_e  = (hm >= 2);
            vs_e  = (vm >= 1);
            fs_e  = (m % 120 == 0);
            ls_e  = (hm == 0);
        end
        check($sformatf("de@%0d",   n), 32'(lcd_de),      32'(de_e));
        check($sformatf("rgb@%0d",  n), 32'(lcd_rgb),     32'(rgb_e));
        check($sformatf("hs@%0d",   n), 32'(lcd_hs),      32'(hs_e));
        check($sformatf("vs@%0d",   n), 32'(lcd_vs),      32'(vs_e));
        check($sformatf("fs@%0d",   n), 32'(frame_start), 32'(fs_e));
        check($sformatf("ls@%0d",   n), 32'(line_start),  32'(ls_e));
        check($sformatf("de_b@%0d", n), 32'(lcd_de_b),    32'(de_e));
        check($sformatf("rgb_b@%0d", n), 32'(lcd_rgb_b),  32'(rgb_e));
        check($sformatf("hs_b@%0d", n), 32'(lcd_hs_b),    32'd1);
        check($sformatf("vs_b@%0d", n), 32'(lcd_vs_b),    32'd1);

        if (n == 0) req_cnt = 0;
        if (data_req) req_cnt++;
        if (h == 14 && v == 7) begin
            check($sformatf("req_per_frame%0d", f), 32'(req_cnt), (fen[f] != 0) ? 32'd32 : 32'd0);
            req_cnt = 0;
        end
    endtask

    task automatic run_span(input int n0, input int n1);
        for (int n = n0; n <= n1; n++) begin
            if (n != 0) tick();
            check_cycle(n);
        end
    endtask

    initial begin
        sys_rst    = 1'b1;
        disp_en    = 1'b1;
        pixel_data = 16'h0000;
        pend       = 16'hBEEF;
        fen        = '{0, 1, 1, 0, 1, 1};

        repeat (3) @(posedge clk);
        #1;
        reset_seq("por");

        // Frame 0 dark, frames 1-2 on; disp_en drops inside frame 2 and returns inside frame 3.
        run_span(0, 299);
        disp_en = 1'b0;
        run_span(300, 399);
        disp_en = 1'b1;
        run_span(400, 668);

        // Frame 5, row 1, column 2 is on the panel: reset right in the middle of it.
        check("pre_rst_de", 32'(lcd_de), 32'd1);
        sys_rst = 1'b1;
        tick();
        reset_seq("mid");
        fen = '{0, 1, 0, 0, 0, 0};
        run_span(0, 239);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
